lsu_mem_unit: RTL and testbench

- Load/store unit directly downstream of the single-cycle datapath.
- Consumes ALUResult as the effective address, plus WriteData, funct3 and the load/store strobes. Produces the formatted ReadData that feeds the datapath's result mux.
- Drives a request/grant/rvalid data bus with variable wait states, so it must stall the core for multi-cycle accesses.
- Also handles byte-lane steering, sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/lsu_mem_unit_if.sv | 23 ++
 rtl/lsu_mem_unit.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_unit_if.sv
// Data-bus interface between the load/store unit and memory.
// Request/grant/rvalid handshake with word-aligned address and byte enables.
//   req    : access request, held stable until gnt
//   we     : 1 = write
//   addr   : word-aligned byte address
//   be     : byte enables
//   wdata  : lane-steered write data
//   gnt    : request accepted (write complete / read address taken)
//   rvalid : read data valid
//   rdata  : read data word
interface lsu_mem_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_unit.sv
// Load/store unit sitting after the single-cycle datapath.
// Takes the ALU result as effective address, steers store data onto byte
// lanes, formats load data (sign/zero extension), detects misaligned or
// illegal accesses, and stalls the core while the bus access is in flight.
// A bus access that does not complete within TIMEOUT cycles is aborted and
// reported with a one-cycle BusError pulse.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite : load / store strobes of the current instruction
//   funct3            : access size/sign (B, H, W, BU, HU)
//   ALUResult         : effective byte address
//   WriteData         : store data
//   ReadData          : formatted load result (valid in the retiring cycle)
//   Stall             : hold PC and register file
//   MisalignedFault   : misaligned access or illegal funct3, no bus access
//   BusError          : one-cycle pulse on bus timeout
//   bus               : data-bus master port
module lsu_mem_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           funct3,
  input  logic [31:0]          ALUResult,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 Stall,
  output logic                 MisalignedFault,
  output logic                 BusError,
  lsu_mem_unit_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             access, fault, illegal_f3, misaligned;
  logic             stall_c, fault_c;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      shifted;
  logic [15:0]      sel_h;
  logic [31:0]      fmt;

  // Access classification
  always_comb begin
    access     = MemRead | MemWrite;
    illegal_f3 = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
    fault      = illegal_f3 | misaligned | (MemRead & MemWrite);
  end

  // Store lane steering
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteData;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUResult[1:0];
        st_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting from the captured word and latched byte offset
  always_comb begin
    shifted = rdata_q >> {off_q, 3'b000};
    sel_h   = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  fmt = {24'b0, shifted[7:0]};
      3'b001:  fmt = {{16{sel_h[15]}}, sel_h};
      3'b101:  fmt = {16'b0, sel_h};
      default: fmt = rdata_q;
    endcase
  end

  // Next-state and control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    fault_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (fault) begin
            fault_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = S_REQ;
            cnt_d   = '0;
            addr_d  = {ALUResult[31:2], 2'b00};
            off_d   = ALUResult[1:0];
            be_d    = MemWrite ? st_be : 4'b1111;
            wdata_d = MemWrite ? st_wdata : '0;
            we_d    = MemWrite;
            f3_d    = funct3;
            rdata_d = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (bus.gnt && we_q) begin
          state_d = S_DONE;
        end else if (bus.gnt && bus.rvalid) begin
          rdata_d = bus.rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // A read grant without data in the last cycle still times out.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus.gnt) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (bus.rvalid) begin
          rdata_d = bus.rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // IDLE-state outputs depend on live inputs, so gate them with reset to
  // keep every output at 0 while reset is held.
  assign Stall           = stall_c & reset;
  assign MisalignedFault = fault_c & reset;
  assign BusError        = (state_q == S_DONE) & err_q;
  assign ReadData        = ((state_q == S_DONE) && !err_q) ? fmt : '0;

  assign bus.req   = (state_q == S_REQ);
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
module tb_lsu_mem_unit;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, MisalignedFault, BusError;

  int checks = 0;
  int errors = 0;

  lsu_mem_unit_if bus_if();

  lsu_mem_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .MisalignedFault(MisalignedFault), .BusError(BusError),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(input logic [2:0] f3);
    int unsigned s;
    s = f3 % 4;
    if (s == 0) return 1;
    if (s == 1) return 2;
    return 4;
  endfunction

  function automatic bit exp_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned v;
    int unsigned off;
    off = a % 4;
    v = w;
    if (size_of(f3) == 1) begin
      v = (w / (1 << (8 * off))) % 256;
      if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size_of(f3) == 2) begin
      v = (w / (1 << (8 * off))) % 65536;
      if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    if (ld) return 4'd15;
    sz = size_of(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (size_of(f3) == 1) return (w % 256) * 32'h01010101;
    if (size_of(f3) == 2) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  // One complete access: issue cycle, REQ/WAIT_R cycles, DONE cycle.
  // gd = REQ cycles before gnt, rv = cycles from gnt to rvalid (loads).
  task automatic do_access(input string tag, input bit ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned gd, input int unsigned rv, input logic [31:0] rd);
    int unsigned fin;
    bit to;
    logic [31:0] exp_rd;
    fin    = ld ? gd + rv : gd;
    to     = (fin >= TIMEOUT);
    exp_rd = to ? 32'h0 : exp_load(f3, a, rd);

    @(negedge clk);
    MemRead = ld; MemWrite = !ld; funct3 = f3; ALUResult = a; WriteData = wd;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = $urandom;
    #1;
    checks++;
    if (Stall !== 1'b1 || MisalignedFault !== 1'b0 || bus_if.req !== 1'b0 || BusError !== 1'b0) begin
      errors++;
      $display("FAIL %s issue: Stall=%b fault=%b req=%b berr=%b, want 1 0 0 0",
               tag, Stall, MisalignedFault, bus_if.req, BusError);
    end

    for (int unsigned n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      bus_if.gnt    = (n == gd);
      bus_if.rvalid = ld && (n == gd + rv);
      bus_if.rdata  = (n == gd + rv) ? rd : $urandom;
      #1;
      checks++;
      if (Stall !== 1'b1 || bus_if.req !== (n <= gd) || BusError !== 1'b0 || MisalignedFault !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: Stall=%b req=%b berr=%b fault=%b, want 1 %b 0 0",
                 tag, n, Stall, bus_if.req, BusError, MisalignedFault, (n <= gd));
      end
      if (n <= gd) begin
        checks++;
        if (bus_if.addr !== (a & 32'hFFFFFFFC) || bus_if.we !== !ld ||
            bus_if.be !== exp_be(ld, f3, a) || (!ld && bus_if.wdata !== exp_wdata(f3, wd))) begin
          errors++;
          $display("FAIL %s bus fields: addr=%h we=%b be=%b wdata=%h, want %h %b %b %h",
                   tag, bus_if.addr, bus_if.we, bus_if.be, bus_if.wdata,
                   a & 32'hFFFFFFFC, !ld, exp_be(ld, f3, a), exp_wdata(f3, wd));
        end
      end
      if (n == fin) break;
    end

    @(negedge clk);
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = $urandom;
    #1;
    checks++;
    if (Stall !== 1'b0 || bus_if.req !== 1'b0 || BusError !== to) begin
      errors++;
      $display("FAIL %s done: Stall=%b req=%b berr=%b, want 0 0 %b", tag, Stall, bus_if.req, BusError, to);
    end
    if (ld || to) begin
      checks++;
      if (ReadData !== exp_rd) begin
        errors++;
        $display("FAIL %s ReadData: got %h want %h", tag, ReadData, exp_rd);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    bus_if.gnt = 1'($urandom); bus_if.rvalid = 1'($urandom); bus_if.rdata = $urandom;
    #1;
    checks++;
    if (Stall !== 1'b0 || MisalignedFault !== 1'b0 || BusError !== 1'b0 || bus_if.req !== 1'b0 || ReadData !== 32'h0) begin
      errors++;
      $display("FAIL idle: Stall=%b fault=%b berr=%b req=%b rd=%h, want all 0",
               Stall, MisalignedFault, BusError, bus_if.req, ReadData);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h100; WriteData = 32'h1;
    bus_if.gnt = 1'b1; bus_if.rvalid = 1'b1; bus_if.rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ReadData !== 32'h0 || Stall !== 1'b0 || MisalignedFault !== 1'b0 || BusError !== 1'b0 ||
        bus_if.req !== 1'b0 || bus_if.we !== 1'b0 || bus_if.addr !== 32'h0 ||
        bus_if.be !== 4'h0 || bus_if.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: rd=%h st=%b mf=%b be=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
               ReadData, Stall, MisalignedFault, BusError, bus_if.req, bus_if.we,
               bus_if.addr, bus_if.be, bus_if.wdata);
    end
    @(negedge clk);
    MemRead = 1'b0; bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_directed();
    do_access("SW", 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    idle_cycle();
    do_access("LB", 1'b1, 3'b000, 32'h203, 32'h0, 0, 2, 32'h80112233);
    idle_cycle();
    do_access("LBU", 1'b1, 3'b100, 32'h203, 32'h0, 0, 2, 32'h80112233);
    idle_cycle();
    do_access("LH", 1'b1, 3'b001, 32'h202, 32'h0, 0, 0, 32'h7FFF0000);
    idle_cycle();
    do_access("SH", 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 1, 0, 32'h0);
    idle_cycle();
    do_access("SB", 1'b0, 3'b000, 32'h301, 32'h000000A5, 2, 0, 32'h0);
    idle_cycle();
  endtask

  task automatic test_misaligned();
    logic [31:0] a;
    logic [2:0]  f3;
    bit rd, wr;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin rd = 1; wr = 0; f3 = 3'b010; a = 32'h101; end
        1: begin rd = 1; wr = 0; f3 = 3'b001; a = 32'h103; end
        2: begin rd = 1; wr = 0; f3 = 3'b011; a = 32'h100; end
        3: begin rd = 1; wr = 1; f3 = 3'b010; a = 32'h100; end
        4: begin rd = 0; wr = 1; f3 = 3'b010; a = 32'h102; end
        5: begin rd = 0; wr = 1; f3 = 3'b001; a = 32'h201; end
        6: begin rd = 1; wr = 0; f3 = 3'b101; a = 32'h205; end
        7: begin rd = 1; wr = 0; f3 = 3'b110; a = 32'h0; end
        default: begin
          rd = 1'($urandom); wr = !rd;
          f3 = 3'($urandom); a = $urandom | 32'h1;
        end
      endcase
      if (!exp_fault(rd, wr, f3, a)) continue;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = $urandom;
      bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (c == 1) @(negedge clk);
        #1;
        checks++;
        if (MisalignedFault !== 1'b1 || Stall !== 1'b0 || bus_if.req !== 1'b0 || ReadData !== 32'h0) begin
          errors++;
          $display("FAIL fault case %0d cyc %0d: mf=%b st=%b req=%b rd=%h, want 1 0 0 0",
                   i, c, MisalignedFault, Stall, bus_if.req, ReadData);
        end
      end
    end
    idle_cycle();
  endtask

  task automatic test_timeout();
    do_access("LW timeout", 1'b1, 3'b010, 32'h400, 32'h0, 0, 100, 32'h12345678);
    idle_cycle();
    do_access("SW timeout", 1'b0, 3'b010, 32'h404, 32'h55AA55AA, 100, 0, 32'h0);
    idle_cycle();
    do_access("LW last cycle", 1'b1, 3'b010, 32'h408, 32'h0, 3, TIMEOUT - 4, 32'hCAFEF00D);
    idle_cycle();
    do_access("SW last cycle", 1'b0, 3'b010, 32'h40C, 32'h01020304, TIMEOUT - 1, 0, 32'h0);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_access("b2b LW", 1'b1, 3'b010, 32'h500, 32'h0, 1, 1, 32'h89ABCDEF);
    do_access("b2b SB", 1'b0, 3'b000, 32'h502, 32'h77, 0, 0, 32'h0);
    do_access("b2b LHU", 1'b1, 3'b101, 32'h506, 32'h0, 2, 0, 32'h9000ABCD);
    idle_cycle();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h600;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
    @(negedge clk);
    bus_if.gnt = 1'b1;
    @(negedge clk);
    bus_if.gnt = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b1 || bus_if.req !== 1'b0) begin
      errors++;
      $display("FAIL wait_r before reset: st=%b req=%b, want 1 0", Stall, bus_if.req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || bus_if.req !== 1'b0 || ReadData !== 32'h0 || bus_if.addr !== 32'h0) begin
      errors++;
      $display("FAIL reset mid-access: st=%b req=%b rd=%h addr=%h, want 0 0 0 0",
               Stall, bus_if.req, ReadData, bus_if.addr);
    end
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b0;
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'hBADBAD00;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin @(negedge clk); bus_if.rvalid = 1'b0; end
      #1;
      checks++;
      if (Stall !== 1'b0 || BusError !== 1'b0 || ReadData !== 32'h0 || bus_if.req !== 1'b0) begin
        errors++;
        $display("FAIL late rvalid cyc %0d: st=%b berr=%b rd=%h req=%b, want 0 0 0 0",
                 c, Stall, BusError, ReadData, bus_if.req);
      end
    end
    do_access("SW after reset", 1'b0, 3'b010, 32'h700, 32'hA5A5F00F, 1, 0, 32'h0);
    idle_cycle();
  endtask

  task automatic test_random();
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    int unsigned k;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom);
      k  = ld ? $urandom_range(4, 0) : $urandom_range(2, 0);
      f3 = (k == 3) ? 3'b100 : (k == 4) ? 3'b101 : 3'(k);
      a  = $urandom;
      a  = a - (a % size_of(f3));
      do_access("random", ld, f3, a, $urandom, $urandom_range(3, 0), $urandom_range(3, 0), $urandom);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0; ALUResult = '0; WriteData = '0;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
